mux_rr_reg: RTL and testbench
=============================

Name: mux_rr_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake on every port. Generalises the fixed 4x1 combinational mux.
- Two select modes:
  - direct: an external select input picks the channel.
  - round-robin: fair scan over the channels that have valid data.
- Sits between several producer channels and one shared consumer, e.g. a shared display or UART path.

Parameters:
- N, 4, number of input channels (2..16)
- W, 8, data width per channel (1..32)
- SW, $clog2(N), select/channel-index width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = direct select, 1 = round-robin
- sel  in  SW  channel index used in direct mode
- in_data  in  N*W  packed channel data; channel i = in_data[i*W +: W]
- in_valid  in  N  per-channel data valid
- in_ready  out  N  per-channel accept; combinational, one-hot or zero
- d  out  W  registered output data
- d_valid  out  1  output register holds data
- d_ch  out  SW  index of the channel that supplied d
- d_ready  in  1  consumer accepts d

Behaviour:
- Reset: one clock and one reset only; reset is asynchronous and active-high, as fixed for this block. While rst is high:
  - d = 0, d_valid = 0, d_ch = 0
  - round-robin pointer ptr = N-1, so channel 0 has first priority after reset
  - rst asserted mid-transfer discards the held word; no partial state survives.
- Load enable: load = !d_valid | d_ready. This gives single-register throughput of one word per cycle, with no bubble under continuous d_ready.
- Grant, direct mode (mode = 0):
  - candidate = sel; grant only if sel < N and in_valid[sel].
  - sel >= N (non-power-of-2 N) gives no grant; d_valid drops once the current word is consumed.
  - ptr is not updated in direct mode.
- Grant, round-robin mode (mode = 1):
  - grant the first i with in_valid[i], scanning ptr+1, ptr+2, ... with wrap modulo N.
  - on a grant that is accepted (load = 1), ptr <= granted index.
- in_ready[g] = load & grant_valid for granted channel g; all other bits are 0. A transfer occurs on a channel when in_valid[i] & in_ready[i].
- Register update on a clk edge with load = 1:
  - grant_valid = 1: d <= channel data, d_ch <= g, d_valid <= 1.
  - no grant: d_valid <= 0; d and d_ch hold their last values.
- load = 0 (output stalled): d, d_ch, d_valid and ptr hold; in_ready = 0.
- Latency: one cycle from accepted input to d_valid.
- A mode change takes effect in the same cycle for grant computation. ptr is retained across mode switches.
- Simultaneous consume and load: the old word leaves and the new word enters on the same edge.
- If no channel is valid and d_ready = 1, the output drains to empty.
- Input protocol: data must be stable while in_valid is high and not yet accepted. The block does not check this.

Optional Feature:
- Macro: MUX_XFER_CNT_EN
- Defined:
  - adds output port xfer_cnt [15:0], the count of output handshakes (d_valid & d_ready).
  - reset to 0; wraps 0xFFFF -> 0x0000.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - MODE_DIRECT = 1'b0, MODE_RR = 1'b1
  - maximum-N/W limits used by parameter range assertions
- One sub-module, rr_arbiter (N):
  - inputs: req[N], ptr, enable
  - outputs: grant index, grant_valid
  - purely combinational rotate-priority encoder
- The top level owns the registers, the handshake and the mode mux.

Test Plan:
- Reset mid-operation: hold d_valid = 1 with d = 0x5A, assert rst asynchronously between clock edges -> d = 0, d_valid = 0, d_ch = 0 immediately; after release, round-robin grants channel 0 first.
- Direct mode, N = 4, W = 8: sel = 2, in_valid = 4'b1111, data ch2 = 0xC3, d_ready = 1 -> next edge d = 0xC3, d_ch = 2; in_ready = 4'b0100 every cycle; one word per cycle.
- Round-robin fairness: all four channels valid continuously, d_ready = 1 -> d_ch sequence 0,1,2,3,0,1...; each channel is granted exactly once per 4 cycles.
- Backpressure:
  - setup: round-robin mode with ch1 valid (0x11); d_ready = 0 for 3 cycles, then 1.
  - while stalled: d holds 0x11, in_ready = 0.
  - on release: the next word loads on the same edge as the consume, with no bubble.
- Sparse requests plus pointer wrap:
  - stimulus: round-robin mode, only ch3 and ch1 valid, starting from ptr = 3.
  - required response: grants alternate 1, 3, 1, 3.
  - then direct mode with sel = 3 and in_valid[3] = 0 -> d_valid deasserts after the current word drains.
- MUX_XFER_CNT_EN defined: 70000 handshakes -> xfer_cnt = 70000 mod 65536 = 4464; no count increments while d_ready = 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the round-robin registered multiplexer.
// Holds the mode encodings and the parameter range limits.
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   localparam int MIN_N = 2;
   localparam int MAX_N = 16;
   localparam int MIN_W = 1;
   localparam int MAX_W = 32;

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after ptr wins,
// scanning upward with wrap.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          enable,
   output logic [SW-1:0] grant,
   output logic          grant_valid
);

   // Scan from farthest to nearest so the nearest requester is written last.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (enable && req[(int'(ptr) + k) % N]) begin
            grant       = SW'((int'(ptr) + k) % N);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel registered mux with valid/ready handshakes, direct or round-robin
// select. Define MUX_XFER_CNT_EN to add the xfer_cnt handshake counter port.
module mux_rr_reg
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   d,
   output logic           d_valid,
   output logic [SW-1:0]  d_ch,
   input  logic           d_ready
`ifdef MUX_XFER_CNT_EN
   ,
   output logic [15:0]    xfer_cnt
`endif
);

   if (N < MIN_N || N > MAX_N || W < MIN_W || W > MAX_W) begin : g_param_err
      $error("mux_rr_reg: N or W out of range");
   end

   logic [W-1:0]      data_q, data_d;
   logic              dv_q, dv_d;
   logic [SW-1:0]     ch_q, ch_d;
   logic [SW-1:0]     ptr_q, ptr_d;
   logic              load;
   logic              gv, rr_gv;
   logic [SW-1:0]     g, rr_g;
   logic [2**SW-1:0]  vpad;
   logic [W-1:0]      dsel;

   assign load = !dv_q || d_ready;

   rr_arbiter #(
      .N  (N),
      .SW (SW)
   ) u_arb (
      .req         (in_valid),
      .ptr         (ptr_q),
      .enable      (mode == MODE_RR),
      .grant       (rr_g),
      .grant_valid (rr_gv)
   );

   // Padding makes sel >= N read as "not valid" for non-power-of-2 N.
   always_comb begin
      vpad         = '0;
      vpad[N-1:0]  = in_valid;
      if (mode == MODE_RR) begin
         g  = rr_g;
         gv = rr_gv;
      end else begin
         g  = sel;
         gv = vpad[sel];
      end
   end

   always_comb begin
      dsel     = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (g == SW'(i)) begin
            dsel        = in_data[i*W +: W];
            in_ready[i] = load && gv;
         end
      end
   end

   always_comb begin
      data_d = data_q;
      dv_d   = dv_q;
      ch_d   = ch_q;
      ptr_d  = ptr_q;
      if (load) begin
         dv_d = gv;
         if (gv) begin
            data_d = dsel;
            ch_d   = g;
            if (mode == MODE_RR) ptr_d = g;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         dv_q   <= 1'b0;
         ch_q   <= '0;
         ptr_q  <= SW'(N - 1);
      end else begin
         data_q <= data_d;
         dv_q   <= dv_d;
         ch_q   <= ch_d;
         ptr_q  <= ptr_d;
      end
   end

   assign d       = data_q;
   assign d_valid = dv_q;
   assign d_ch    = ch_q;

`ifdef MUX_XFER_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt_q <= '0;
      else if (dv_q && d_ready) cnt_q <= cnt_q + 16'd1;
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: vector table, corner sequences and
// randomized traffic against a grant-rule reference model.
module tb_mux_rr_reg;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   d;
   logic           d_valid;
   logic [SW-1:0]  d_ch;
   logic           d_ready;
`ifdef MUX_XFER_CNT_EN
   logic [15:0]    xfer_cnt;
`endif

   mux_rr_reg #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .sel      (sel),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .d        (d),
      .d_valid  (d_valid),
      .d_ch     (d_ch),
      .d_ready  (d_ready)
`ifdef MUX_XFER_CNT_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: the word in the output register and the last RR winner.
   logic [W-1:0] m_d;
   bit           m_dv;
   int           m_ch;
   int           m_ptr;
   int           m_cnt;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_d   = '0;
      m_dv  = 0;
      m_ch  = 0;
      m_ptr = N - 1;
      m_cnt = 0;
   endtask

   function automatic void model_grant(output bit ok, output int g);
      ok = 0;
      g  = 0;
      if (mode == 1'b0) begin
         if (int'(sel) < N && in_valid[sel]) begin
            ok = 1;
            g  = int'(sel);
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            if (in_valid[(m_ptr + k) % N]) begin
               ok = 1;
               g  = (m_ptr + k) % N;
            end
         end
      end
   endfunction

   // One clock: check in_ready before the edge, outputs after it.
   task automatic cyc();
      bit           ok;
      int           g;
      bit           ld;
      logic [N-1:0] er;
      #1;
      ld = !m_dv || d_ready;
      model_grant(ok, g);
      er = '0;
      if (ld && ok) er[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (m_dv && d_ready) m_cnt = (m_cnt + 1) % 65536;
      if (ld) begin
         if (ok) begin
            m_d  = in_data[g*W +: W];
            m_ch = g;
            m_dv = 1;
            if (mode) m_ptr = g;
         end else begin
            m_dv = 0;
         end
      end
      #1;
      chk("d", 32'(d), 32'(m_d));
      chk("d_valid", 32'(d_valid), 32'(m_dv));
      chk("d_ch", 32'(d_ch), 32'(m_ch));
`ifdef MUX_XFER_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("rst_d", 32'(d), 0);
      chk("rst_dv", 32'(d_valid), 0);
      chk("rst_ch", 32'(d_ch), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic          mode;
      logic [SW-1:0] sel;
      logic [N-1:0]  valid;
      logic          dr;
      logic [N-1:0]  rdy;
      logic [W-1:0]  ed;
      logic          edv;
      logic [SW-1:0] ech;
   } vec_t;

   vec_t vt[12];
   int   cnt_ch[N];

   initial begin
      rst      = 1'b1;
      mode     = 1'b0;
      sel      = '0;
      in_data  = '0;
      in_valid = '0;
      d_ready  = 1'b0;
      model_reset();

      vt[0]  = '{0, 2, 4'b1111, 1, 4'b0100, 8'hC3, 1, 2};
      vt[1]  = '{0, 2, 4'b1111, 1, 4'b0100, 8'hC3, 1, 2};
      vt[2]  = '{0, 0, 4'b0001, 1, 4'b0001, 8'hA1, 1, 0};
      vt[3]  = '{0, 3, 4'b0111, 1, 4'b0000, 8'hA1, 0, 0};
      vt[4]  = '{1, 0, 4'b1111, 1, 4'b0001, 8'hA1, 1, 0};
      vt[5]  = '{1, 0, 4'b1111, 1, 4'b0010, 8'hB2, 1, 1};
      vt[6]  = '{1, 0, 4'b0100, 0, 4'b0000, 8'hB2, 1, 1};
      vt[7]  = '{1, 0, 4'b0100, 1, 4'b0100, 8'hC3, 1, 2};
      vt[8]  = '{1, 0, 4'b0000, 1, 4'b0000, 8'hC3, 0, 2};
      vt[9]  = '{0, 1, 4'b0010, 0, 4'b0010, 8'hB2, 1, 1};
      vt[10] = '{1, 0, 4'b1010, 1, 4'b1000, 8'hD4, 1, 3};
      vt[11] = '{1, 0, 4'b1010, 1, 4'b0010, 8'hB2, 1, 1};

      repeat (2) @(negedge clk);
      #2;
      chk("rst_d", 32'(d), 0);
      chk("rst_dv", 32'(d_valid), 0);
      chk("rst_ch", 32'(d_ch), 0);
      @(negedge clk);
      rst = 1'b0;

      in_data = 32'hD4C3B2A1;
      foreach (vt[i]) begin
         mode     = vt[i].mode;
         sel      = vt[i].sel;
         in_valid = vt[i].valid;
         d_ready  = vt[i].dr;
         #1;
         chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vt[i].rdy));
         cyc();
         chk($sformatf("vec%0d_d", i), 32'(d), 32'(vt[i].ed));
         chk($sformatf("vec%0d_dv", i), 32'(d_valid), 32'(vt[i].edv));
         chk($sformatf("vec%0d_ch", i), 32'(d_ch), 32'(vt[i].ech));
      end

      // Asynchronous reset while a word is held under backpressure.
      mode     = 1'b0;
      sel      = 0;
      in_data  = 32'h0000005A;
      in_valid = 4'b0001;
      d_ready  = 1'b1;
      cyc();
      d_ready = 1'b0;
      cyc();
      chk("hold_5a", 32'(d), 32'h5A);
      #3;
      rst = 1'b1;
      #1;
      chk("async_d", 32'(d), 0);
      chk("async_dv", 32'(d_valid), 0);
      chk("async_ch", 32'(d_ch), 0);
      model_reset();
      @(negedge clk);
      rst      = 1'b0;
      mode     = 1'b1;
      in_data  = 32'h44332211;
      in_valid = 4'b1111;
      d_ready  = 1'b1;
      cyc();
      chk("first_rr_ch", 32'(d_ch), 0);

      // Fairness with every channel requesting.
      foreach (cnt_ch[i]) cnt_ch[i] = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("fair_seq", 32'(d_ch), 32'((i + 1) % 4));
         cnt_ch[d_ch]++;
      end
      foreach (cnt_ch[i]) chk("fair_cnt", 32'(cnt_ch[i]), 2);

      // Backpressure: stall three cycles, then consume and load together.
      do_reset();
      mode     = 1'b1;
      in_data  = 32'h00001100;
      in_valid = 4'b0010;
      d_ready  = 1'b1;
      cyc();
      chk("bp_load", 32'(d), 32'h11);
      d_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("bp_rdy", 32'(in_ready), 0);
         cyc();
         chk("bp_hold", 32'(d), 32'h11);
      end
      in_data = 32'h00002200;
      d_ready = 1'b1;
      cyc();
      chk("bp_next", 32'(d), 32'h22);
      chk("bp_nobubble", 32'(d_valid), 1);

      // Sparse requesters with pointer wrap, then a direct-mode drain.
      do_reset();
      mode     = 1'b1;
      in_data  = 32'h33221100;
      in_valid = 4'b1010;
      d_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("sparse", 32'(d_ch), (i % 2 == 0) ? 1 : 3);
      end
      mode     = 1'b0;
      sel      = 3;
      in_valid = 4'b0010;
      d_ready  = 1'b0;
      cyc();
      chk("drain_hold", 32'(d_valid), 1);
      d_ready = 1'b1;
      cyc();
      chk("drain_empty", 32'(d_valid), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         mode     = 1'($urandom);
         sel      = SW'($urandom);
         in_data  = $urandom;
         in_valid = N'($urandom);
         d_ready  = ($urandom_range(0, 3) != 0);
         cyc();
      end

`ifdef MUX_XFER_CNT_EN
      do_reset();
      mode     = 1'b1;
      in_valid = 4'b1111;
      d_ready  = 1'b1;
      for (int i = 0; i < 70001; i++) begin
         in_data = $urandom;
         cyc();
      end
      chk("cnt_wrap", 32'(xfer_cnt), 4464);
      d_ready = 1'b0;
      repeat (3) cyc();
      chk("cnt_stall", 32'(xfer_cnt), 4464);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
